// File: rtl/boolean_if.sv
// Operand/result bundle for the boolean function unit.
// master drives the operands and observes the result; slave is the unit itself.
interface boolean_if;
    logic a;
    logic b;
    logic c;
    logic e;

    modport master (output a, output b, output c, input e);
    modport slave  (input a, input b, input c, output e);
endinterface

// File: rtl/boolean.sv
// Clocked three-input Boolean function unit: e = TRUTH_TABLE[{a,b,c}].
// Operands are synchronized, evaluated, and the result is registered.
module boolean #(
    parameter logic [7:0] TRUTH_TABLE = 8'hCA,
    parameter int          SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    boolean_if.slave  bus
);

    logic [2:0] raw;
    logic [2:0] sync_out;
    logic       e_q;

    assign raw = {bus.a, bus.b, bus.c};

    generate
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_stages
            $error("boolean: SYNC_STAGES must be in 0..3");
        end else if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_out = raw;
        end else begin : g_sync
            // one independent chain per bit; bits share only the clock
            logic [2:0] chain [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        chain[i] <= '0;
                    end
                end else begin
                    chain[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign sync_out = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= 1'b0;
        end else begin
            e_q <= TRUTH_TABLE[sync_out];
        end
    end

    assign bus.e = e_q;

endmodule

// File: tb/tb_boolean.sv
// Bench for boolean: default mux instance and an XOR3 instance with no
// synchronizer, both compared every cycle against a history-based model.
module tb_boolean;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;

    int nvec = 0;
    int nerr = 0;

    // per-edge history of {rst, a, b, c} as seen at each rising edge
    logic [3:0] hist [$];
    int first_rst = -1;

    boolean_if bus0 ();
    boolean_if bus1 ();

    assign bus0.a = a;
    assign bus0.b = b;
    assign bus0.c = c;
    assign bus1.a = a;
    assign bus1.b = b;
    assign bus1.c = c;

    boolean dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    boolean #(.TRUTH_TABLE(8'h96), .SYNC_STAGES(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // sel 0: a ? b : c    sel 1: a ^ b ^ c
    function automatic logic f_ref(int sel, logic [2:0] abc);
        logic fa, fb, fc;
        fa = abc[2];
        fb = abc[1];
        fc = abc[0];
        if (sel == 0) return fa ? fb : fc;
        return fa ^ fb ^ fc;
    endfunction

    // Result after the latest edge for a unit with n sync stages:
    // 0 if reset sampled now; F(000) if a reset sampled within the last n
    // edges still has zeros in the chain; otherwise F of the inputs n edges ago.
    function automatic logic model(int n, int sel);
        int k;
        k = hist.size() - 1;
        if (hist[k][3]) return 1'b0;
        for (int j = k - n; j < k; j++) begin
            if (j < 0) return f_ref(sel, 3'b000);
            if (hist[j][3]) return f_ref(sel, 3'b000);
        end
        return f_ref(sel, hist[k-n][2:0]);
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        hist.push_back({rst, a, b, c});
        if (rst && first_rst < 0) first_rst = hist.size() - 1;
        #1;
        if (first_rst >= 0) begin
            check("mux_model", bus0.e, model(2, 0));
            check("xor_model", bus1.e, model(0, 1));
        end
    endtask

    task automatic drive(logic [2:0] abc);
        a = abc[2];
        b = abc[1];
        c = abc[0];
    endtask

    initial begin
        logic [2:0] code;

        #1;
        // reset with all inputs high
        rst = 1'b1;
        drive(3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_e0", bus0.e, 1'b0);
            check("reset_e1", bus1.e, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("rel_edge1", bus0.e, 1'b0);
        check("xor_rel_edge1", bus1.e, 1'b1);
        tick();
        check("rel_edge2", bus0.e, 1'b0);
        tick();
        check("rel_edge3", bus0.e, 1'b1);

        // walk all codes, 10 cycles each
        for (int v = 0; v < 8; v++) begin
            code = 3'(v);
            drive(code);
            for (int i = 0; i < 10; i++) tick();
            check("walk_settled", bus0.e, f_ref(0, code));
        end

        // periodic toggles: a every 5, b every 10, c every 15 cycles
        for (int i = 0; i < 100; i++) begin
            a = 1'((i / 5) % 2);
            b = 1'((i / 10) % 2);
            c = 1'((i / 15) % 2);
            tick();
        end

        // one-cycle reset while e is high
        drive(3'b110);
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_high", bus0.e, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_e0", bus0.e, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst1", bus0.e, 1'b0);
        tick();
        check("post_rst2", bus0.e, 1'b0);
        tick();
        check("post_rst3", bus0.e, 1'b1);

        // XOR3 directed
        drive(3'b111);
        tick();
        check("xor_111", bus1.e, 1'b1);
        drive(3'b110);
        tick();
        check("xor_110", bus1.e, 1'b0);

        // a and c change together: 000 -> 101
        drive(3'b000);
        for (int i = 0; i < 5; i++) tick();
        drive(3'b101);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("same_edge_101", bus0.e, 1'b0);
        end
        drive(3'b111);
        for (int i = 0; i < 3; i++) tick();
        check("after_111", bus0.e, 1'b1);

        // random inputs with occasional resets
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
